pc_sequencer: RTL and testbench

- Drives the PC bus into the IF stage and consumes IF's PC_M1 (PC+1) as the sequential next-PC, closing the fetch loop from the initiator side.
- Handles start, stall, branch redirect with a one-cycle flush bubble, halt, and address wrap at a programmable limit.
- Sits between the hazard/branch logic (ID/EX) and IF. Its only feedback from IF is PC_M1.

---
 rtl/pc_sequencer.sv | 69 ++++++
 tb/tb_pc_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: drives the fetch PC into IF, with stall, branch flush bubble, halt and wrap
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_LIMIT = 32'd255,
  parameter int          CNT_W    = 16
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic             STALL,
  input  logic             BRANCH_TAKEN,
  input  logic [31:0]      BRANCH_TARGET,
  input  logic             HALT_REQ,
  input  logic [31:0]      PC_M1,
  output logic [31:0]      PC,
  output logic             PC_VALID,
  output logic             HALTED,
  output logic [CNT_W-1:0] FETCH_COUNT
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} state_t;
  state_t state, state_nx;
  logic [31:0] pc_nx;
  logic adv;
  logic inc;
  assign inc = adv && (FETCH_COUNT != {CNT_W{1'b1}});
  // next state, next PC and advance strobe; branch beats stall, halt beats both
  always_comb begin
    state_nx = state;
    pc_nx = PC;
    adv = 1'b0;
    case (state)
      IDLE: if (START) begin
        state_nx = RUN;
        pc_nx = RESET_PC;
      end
      RUN: if (HALT_REQ) state_nx = HALT;
      else if (BRANCH_TAKEN) begin
        state_nx = FLUSH;
        pc_nx = BRANCH_TARGET;
        adv = 1'b1;
      end else if (!STALL) begin
        pc_nx = (PC_M1 > PC_LIMIT) ? RESET_PC : PC_M1;
        adv = 1'b1;
      end
      FLUSH: state_nx = HALT_REQ ? HALT : RUN;
      HALT: if (START) begin
        state_nx = RUN;
        pc_nx = RESET_PC;
      end
      default: state_nx = IDLE;
    endcase
  end
  // state and registered outputs; valid/halted are flopped from the next state
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      PC <= RESET_PC;
      PC_VALID <= 1'b0;
      HALTED <= 1'b0;
      FETCH_COUNT <= '0;
    end else begin
      state <= state_nx;
      PC <= pc_nx;
      PC_VALID <= state_nx == RUN;
      HALTED <= state_nx == HALT;
      FETCH_COUNT <= FETCH_COUNT + {{(CNT_W-1){1'b0}}, inc};
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of the PC sequencer with IF modelled as PC+1
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst_n, start, stall, branch, halt_req;
  logic [31:0] target, pc, pc_m1;
  logic pc_valid, halted;
  logic [3:0] fc;
  logic [37:0] obs, exp;
  int n_cmp = 0;
  int n_err = 0;
  pc_sequencer #(.RESET_PC(32'd0), .PC_LIMIT(32'd255), .CNT_W(4)) dut (
    .CLOCK(clk), .RESET_N(rst_n), .START(start), .STALL(stall),
    .BRANCH_TAKEN(branch), .BRANCH_TARGET(target), .HALT_REQ(halt_req),
    .PC_M1(pc_m1), .PC(pc), .PC_VALID(pc_valid), .HALTED(halted), .FETCH_COUNT(fc)
  );
  assign pc_m1 = pc + 32'd1;
  assign obs = {pc, pc_valid, halted, fc};
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; branch = 1'b0; halt_req = 1'b0; target = '0;
    #2;
    exp = {32'd0, 1'b0, 1'b0, 4'd0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL reset_values: got %h want %h", obs, exp); end
    step(); step();
    rst_n = 1'b1;
    step(); step();
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL idle_wait: got %h want %h", obs, exp); end
  endtask
  task automatic test_start_run();
    start = 1'b1;
    step();
    start = 1'b0;
    exp = {32'd0, 1'b1, 1'b0, 4'd0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL start_first: got %h want %h", obs, exp); end
    for (int i = 1; i <= 5; i++) begin
      step();
      exp = {32'(i), 1'b1, 1'b0, 4'(i)};
      n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL run_seq%0d: got %h want %h", i, obs, exp); end
    end
  endtask
  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      exp = {32'd5, 1'b1, 1'b0, 4'd5};
      n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL stall_hold%0d: got %h want %h", i, obs, exp); end
    end
    stall = 1'b0;
    step();
    exp = {32'd6, 1'b1, 1'b0, 4'd6};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL stall_release: got %h want %h", obs, exp); end
  endtask
  task automatic test_branch_flush();
    branch = 1'b1; stall = 1'b1; target = 32'h40;
    step();
    exp = {32'h40, 1'b0, 1'b0, 4'd7};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL branch_bubble: got %h want %h", obs, exp); end
    target = 32'h80;
    step();
    exp = {32'h40, 1'b1, 1'b0, 4'd7};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL flush_exit: got %h want %h", obs, exp); end
    branch = 1'b0; stall = 1'b0;
    step();
    exp = {32'h41, 1'b1, 1'b0, 4'd8};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL after_branch: got %h want %h", obs, exp); end
  endtask
  task automatic test_halt();
    branch = 1'b1; target = 32'd8;
    step();
    branch = 1'b0;
    step();
    step();
    exp = {32'd9, 1'b1, 1'b0, 4'd10};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL pre_halt: got %h want %h", obs, exp); end
    halt_req = 1'b1;
    step();
    halt_req = 1'b0; branch = 1'b1; target = 32'h77;
    for (int i = 0; i < 4; i++) begin
      exp = {32'd9, 1'b0, 1'b1, 4'd10};
      n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL halt_hold%0d: got %h want %h", i, obs, exp); end
      step();
    end
    branch = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    exp = {32'd0, 1'b1, 1'b0, 4'd10};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL halt_restart: got %h want %h", obs, exp); end
  endtask
  task automatic test_halt_in_flush();
    branch = 1'b1; target = 32'h20;
    step();
    branch = 1'b0; halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    exp = {32'h20, 1'b0, 1'b1, 4'd11};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL flush_halt: got %h want %h", obs, exp); end
    start = 1'b1;
    step();
    start = 1'b0;
    exp = {32'd0, 1'b1, 1'b0, 4'd11};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL flush_halt_restart: got %h want %h", obs, exp); end
  endtask
  task automatic test_branch_above_limit();
    branch = 1'b1; target = 32'h1F0;
    step();
    branch = 1'b0;
    exp = {32'h1F0, 1'b0, 1'b0, 4'd12};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL far_target: got %h want %h", obs, exp); end
    step();
    step();
    exp = {32'd0, 1'b1, 1'b0, 4'd13};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL far_wrap: got %h want %h", obs, exp); end
  endtask
  task automatic test_wrap_saturate();
    branch = 1'b1; target = 32'hFD;
    step();
    branch = 1'b0;
    step();
    step();
    exp = {32'hFE, 1'b1, 1'b0, 4'd15};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL count_max: got %h want %h", obs, exp); end
    step();
    exp = {32'hFF, 1'b1, 1'b0, 4'd15};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL limit_reached: got %h want %h", obs, exp); end
    step();
    exp = {32'd0, 1'b1, 1'b0, 4'd15};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL wrap_saturated: got %h want %h", obs, exp); end
  endtask
  task automatic test_reset_in_flush();
    branch = 1'b1; target = 32'h30;
    step();
    #2 rst_n = 1'b0;
    #1;
    exp = {32'd0, 1'b0, 1'b0, 4'd0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL async_reset: got %h want %h", obs, exp); end
    step();
    #3 rst_n = 1'b1;
    stall = 1'b1; halt_req = 1'b1;
    step();
    step();
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL post_reset_idle: got %h want %h", obs, exp); end
    branch = 1'b0; stall = 1'b0; halt_req = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    exp = {32'd1, 1'b1, 1'b0, 4'd1};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL post_reset_run: got %h want %h", obs, exp); end
  endtask
  initial begin
    test_reset();
    test_start_run();
    test_stall();
    test_branch_flush();
    test_halt();
    test_halt_in_flush();
    test_branch_above_limit();
    test_wrap_saturate();
    test_reset_in_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
